// File: rtl/serial_detect_scheduler.sv
// serial_detect_scheduler
//
// Arbitrates NREQ requesters for a single serial pattern detector. The
// winning requester's WIDTH-bit word is shifted out MSB first on det_in,
// the detector's Moore output det_out is collected one clock behind each
// bit, and the collected word is presented on result with a done pulse.
//
// Optional feature macro: DET_RST_EN
//   When defined, a one-cycle FLUSH state follows arbitration and drives
//   det_rst so the detector starts every transaction from its reset state.
//   When undefined, there is no det_rst port and detector state carries over
//   between transactions.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   req       in   [NREQ]        per-requester request level
//   data      in   [NREQ*WIDTH]  requester i word at [i*WIDTH +: WIDTH]
//   grant     out  [NREQ]        one-hot owner, zero when idle
//   busy      out                high whenever the FSM is not IDLE
//   det_in    out                serial bit to the detector
//   det_valid out                det_in carries a payload bit
//   det_out   in                 detector Moore output
//   done      out                one-cycle completion pulse
//   done_id   out  [3]           completed requester index, valid with done
//   result    out  [WIDTH]       collected detector outputs, valid with done
//   det_rst   out                detector reset (DET_RST_EN only)
//
// Handshake: a requester holds req high until it sees its grant bit; its data
// word is captured only on the arbitration edge, and dropping req afterwards
// does not cancel the transaction. done is a single-cycle strobe with
// done_id/result valid in that cycle; both hold until the next done.
module serial_detect_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  det_in,
  output logic                  det_valid,
  input  logic                  det_out,
  output logic                  done,
  output logic [2:0]            done_id,
  output logic [WIDTH-1:0]      result
`ifdef DET_RST_EN
  ,
  output logic                  det_rst
`endif
);

  localparam int              CW           = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_BIT     = CW'(WIDTH);
  localparam logic [CW-1:0]   FIRST_SAMPLE = CW'(2);
  localparam logic [NREQ-1:0] ONE_HOT0     = NREQ'(1);
  localparam logic [3:0]      NREQ4        = 4'(NREQ);

  typedef enum logic [2:0] {
    IDLE,
`ifdef DET_RST_EN
    FLUSH,
`endif
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  // state is the FSM debug view; bind checkers to it hierarchically.
  state_t            state;
  state_t            state_n;
  logic [WIDTH-1:0]  sr;
  logic [WIDTH-1:0]  acc;
  logic [CW-1:0]     cnt;
  logic [2:0]        owner;
  logic [2:0]        last_winner;

  logic [7:0]        req8;
  logic [3:0]        cand;
  logic [2:0]        win_idx;
  logic              win_found;
  logic [WIDTH-1:0]  win_word;

  // Round-robin search starting one above the previous winner.
  always_comb begin
    req8      = 8'(req);
    win_found = 1'b0;
    win_idx   = last_winner;
    cand      = 4'd0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_winner} + 4'(k);
      if (cand >= NREQ4) cand = cand - NREQ4;
      if (!win_found && req8[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == 3'(i)) win_word = data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    busy      = (state != IDLE);
    det_valid = (state == SHIFT);
    det_in    = (state == SHIFT) && sr[WIDTH-1];
    done      = (state == DONE);
`ifdef DET_RST_EN
    det_rst   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (win_found) begin
`ifdef DET_RST_EN
          state_n = FLUSH;
`else
          state_n = SHIFT;
`endif
        end
      end
`ifdef DET_RST_EN
      FLUSH: begin
        det_rst = 1'b1;
        state_n = SHIFT;
      end
`endif
      SHIFT:   if (cnt == LAST_BIT) state_n = DRAIN;
      DRAIN:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // det_out lags det_in by one clock, so the first useful sample is in SHIFT
  // cycle 2 and the last one lands in DRAIN. The final sample goes straight
  // into result so result only changes on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr          <= '0;
      acc         <= '0;
      cnt         <= '0;
      owner       <= '0;
      last_winner <= 3'(NREQ - 1);
      grant       <= '0;
      done_id     <= '0;
      result      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            sr          <= win_word;
            acc         <= '0;
            cnt         <= CW'(1);
            owner       <= win_idx;
            last_winner <= win_idx;
            grant       <= ONE_HOT0 << win_idx;
          end
        end
        SHIFT: begin
          sr  <= sr << 1;
          cnt <= cnt + CW'(1);
          if (cnt >= FIRST_SAMPLE) acc <= {acc[WIDTH-2:0], det_out};
        end
        DRAIN: begin
          result  <= {acc[WIDTH-2:0], det_out};
          done_id <= owner;
        end
        DONE: begin
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
